// File: rtl/instruction_issue_unit.sv
// Single-issue front end: registered fetch from a fixed 16-word ROM, decode,
// reservation-slot allocation across four units, 8-entry ROB and a register
// status table that tracks the latest in-flight producer of each register.
module instruction_issue_unit (
   input  logic        clk1,
   input  logic        rst_n,
   input  logic [3:0]  pc,
   input  logic        valid_in,
   input  logic        rob_retire,
   input  logic [2:0]  add_free,
   input  logic [2:0]  mul_free,
   input  logic [1:0]  bch_free,
   input  logic [3:0]  lsq_free,
   output logic [15:0] inst,
   output logic [3:0]  func,
   output logic [3:0]  rs1,
   output logic [3:0]  rs2,
   output logic [3:0]  rd,
   output logic        stall,
   output logic        issued,
   output logic [1:0]  issue_unit,
   output logic [1:0]  issue_slot,
   output logic [2:0]  rob_tag,
   output logic        src1_busy,
   output logic        src2_busy,
   output logic [2:0]  src1_tag,
   output logic [2:0]  src2_tag,
   output logic [3:0]  rob_count
);

   function automatic logic [15:0] rom_word(input logic [3:0] a);
      case (a)
         4'd0:    rom_word = 16'h0123;
         4'd1:    rom_word = 16'h1456;
         4'd2:    rom_word = 16'h2789;
         4'd3:    rom_word = 16'h3ABC;
         4'd4:    rom_word = 16'h4105;
         4'd5:    rom_word = 16'h5206;
         4'd6:    rom_word = 16'h6127;
         4'd7:    rom_word = 16'h7348;
         default: rom_word = 16'hF000;
      endcase
   endfunction

   function automatic logic [1:0] low_idx(input logic [3:0] v);
      low_idx = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (v[i]) low_idx = 2'(i);
   endfunction

   logic [15:0]       inst_q, inst_d;
   logic              fv_q, fv_d;
   logic [2:0]        add_occ_q, add_occ_d, mul_occ_q, mul_occ_d;
   logic [1:0]        bch_occ_q, bch_occ_d;
   logic [3:0]        lsq_occ_q, lsq_occ_d;
   logic [2:0]        head_q, head_d, tail_q, tail_d;
   logic [3:0]        count_q, count_d;
   logic [7:0][3:0]   rob_rd_q, rob_rd_d;
   logic [7:0]        rob_wr_q, rob_wr_d;
   logic [15:0]       busy_q, busy_d;
   logic [15:0][2:0]  reg_tag_q, reg_tag_d;
   logic              issued_q, issued_d;
   logic [1:0]        unit_q, unit_d, slot_q, slot_d;
   logic [2:0]        tag_q, tag_d;
   logic              s1b_q, s1b_d, s2b_q, s2b_d;
   logic [2:0]        s1t_q, s1t_d, s2t_q, s2t_d;

   logic              nop, writes, has_free, do_issue, do_retire;
   logic [1:0]        unit, slot;
   logic [3:0]        avail;

   assign func  = inst_q[15:12];
   assign rs1   = inst_q[11:8];
   assign rs2   = inst_q[7:4];
   assign rd    = inst_q[3:0];
   assign nop   = func[3];
   assign unit  = func[2:1];
   assign writes = ~func[3] & (func <= 4'd4);

   // Free-slot view of the target unit; slots released this cycle are not yet visible
   always_comb begin
      avail = 4'b0000;
      case (unit)
         2'd0:    avail = {1'b0, ~add_occ_q};
         2'd1:    avail = {1'b0, ~mul_occ_q};
         2'd2:    avail = ~lsq_occ_q;
         default: avail = {2'b00, ~bch_occ_q};
      endcase
   end

   assign has_free  = |avail;
   assign slot      = low_idx(avail);
   assign stall     = fv_q & ~nop & ((count_q == 4'd8) | ~has_free);
   assign do_issue  = fv_q & ~nop & ~stall;
   assign do_retire = rob_retire & (count_q != 4'd0);

   // Next-state: fetch, slot occupancy, ROB pointers, register status, issue outputs
   always_comb begin
      inst_d    = inst_q;
      fv_d      = fv_q;
      add_occ_d = add_occ_q & ~add_free;
      mul_occ_d = mul_occ_q & ~mul_free;
      bch_occ_d = bch_occ_q & ~bch_free;
      lsq_occ_d = lsq_occ_q & ~lsq_free;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      rob_rd_d  = rob_rd_q;
      rob_wr_d  = rob_wr_q;
      busy_d    = busy_q;
      reg_tag_d = reg_tag_q;
      issued_d  = 1'b0;
      unit_d    = unit_q;
      slot_d    = slot_q;
      tag_d     = tag_q;
      s1b_d     = s1b_q;
      s2b_d     = s2b_q;
      s1t_d     = s1t_q;
      s2t_d     = s2t_q;

      if (!stall) begin
         fv_d = valid_in;
         if (valid_in) inst_d = rom_word(pc);
      end

      // retire clears first so a same-cycle issue to the same register wins
      if (do_retire) begin
         head_d = head_q + 3'd1;
         if (rob_wr_q[head_q] && reg_tag_q[rob_rd_q[head_q]] == head_q)
            busy_d[rob_rd_q[head_q]] = 1'b0;
      end

      if (do_issue) begin
         case (unit)
            2'd0:    add_occ_d[slot] = 1'b1;
            2'd1:    mul_occ_d[slot] = 1'b1;
            2'd2:    lsq_occ_d[slot] = 1'b1;
            default: bch_occ_d[slot[0]] = 1'b1;
         endcase
         rob_rd_d[tail_q] = rd;
         rob_wr_d[tail_q] = writes;
         tail_d   = tail_q + 3'd1;
         issued_d = 1'b1;
         unit_d   = unit;
         slot_d   = slot;
         tag_d    = tail_q;
         if (unit[1] == 1'b0) begin
            s1b_d = busy_q[rs1];
            s2b_d = busy_q[rs2];
            s1t_d = reg_tag_q[rs1];
            s2t_d = reg_tag_q[rs2];
         end else begin
            s1b_d = 1'b0;
            s2b_d = 1'b0;
            s1t_d = 3'd0;
            s2t_d = 3'd0;
         end
         if (writes) begin
            busy_d[rd]    = 1'b1;
            reg_tag_d[rd] = tail_q;
         end
      end

      case ({do_issue, do_retire})
         2'b10:   count_d = count_q + 4'd1;
         2'b01:   count_d = count_q - 4'd1;
         default: count_d = count_q;
      endcase
   end

   // State registers
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         inst_q    <= '0;
         fv_q      <= 1'b0;
         add_occ_q <= '0;
         mul_occ_q <= '0;
         bch_occ_q <= '0;
         lsq_occ_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         rob_rd_q  <= '0;
         rob_wr_q  <= '0;
         busy_q    <= '0;
         reg_tag_q <= '0;
         issued_q  <= 1'b0;
         unit_q    <= '0;
         slot_q    <= '0;
         tag_q     <= '0;
         s1b_q     <= 1'b0;
         s2b_q     <= 1'b0;
         s1t_q     <= '0;
         s2t_q     <= '0;
      end else begin
         inst_q    <= inst_d;
         fv_q      <= fv_d;
         add_occ_q <= add_occ_d;
         mul_occ_q <= mul_occ_d;
         bch_occ_q <= bch_occ_d;
         lsq_occ_q <= lsq_occ_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         rob_rd_q  <= rob_rd_d;
         rob_wr_q  <= rob_wr_d;
         busy_q    <= busy_d;
         reg_tag_q <= reg_tag_d;
         issued_q  <= issued_d;
         unit_q    <= unit_d;
         slot_q    <= slot_d;
         tag_q     <= tag_d;
         s1b_q     <= s1b_d;
         s2b_q     <= s2b_d;
         s1t_q     <= s1t_d;
         s2t_q     <= s2t_d;
      end
   end

   assign inst       = inst_q;
   assign issued     = issued_q;
   assign issue_unit = unit_q;
   assign issue_slot = slot_q;
   assign rob_tag    = tag_q;
   assign src1_busy  = s1b_q;
   assign src2_busy  = s2b_q;
   assign src1_tag   = s1t_q;
   assign src2_tag   = s2t_q;
   assign rob_count  = count_q;

endmodule

// File: tb/tb_instruction_issue_unit.sv
// Directed bench for instruction_issue_unit with hand-computed expectations.
module tb_instruction_issue_unit;

   logic        clk1 = 1'b0;
   logic        rst_n;
   logic [3:0]  pc;
   logic        valid_in, rob_retire;
   logic [2:0]  add_free, mul_free;
   logic [1:0]  bch_free;
   logic [3:0]  lsq_free;
   logic [15:0] inst;
   logic [3:0]  func, rs1, rs2, rd, rob_count;
   logic        stall, issued, src1_busy, src2_busy;
   logic [1:0]  issue_unit, issue_slot;
   logic [2:0]  rob_tag, src1_tag, src2_tag;

   int n_checks = 0;
   int n_fail   = 0;

   instruction_issue_unit dut (
      .clk1(clk1), .rst_n(rst_n), .pc(pc), .valid_in(valid_in), .rob_retire(rob_retire),
      .add_free(add_free), .mul_free(mul_free), .bch_free(bch_free), .lsq_free(lsq_free),
      .inst(inst), .func(func), .rs1(rs1), .rs2(rs2), .rd(rd), .stall(stall),
      .issued(issued), .issue_unit(issue_unit), .issue_slot(issue_slot), .rob_tag(rob_tag),
      .src1_busy(src1_busy), .src2_busy(src2_busy), .src1_tag(src1_tag), .src2_tag(src2_tag),
      .rob_count(rob_count)
   );

   always #5 clk1 = ~clk1;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; valid_in = 1'b0; pc = 4'd0; rob_retire = 1'b0;
      add_free = '0; mul_free = '0; bch_free = '0; lsq_free = '0;
      #1;
      @(negedge clk1);
      rst_n = 1'b1;
   endtask

   task automatic fetch(input logic [3:0] p);
      valid_in = 1'b1;
      pc = p;
   endtask

   logic [3:0] fill_seq [9];

   initial begin
      fill_seq = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd6, 4'd7, 4'd0, 4'd1, 4'd2};
      rst_n = 1'b0; valid_in = 1'b0; pc = 4'd0; rob_retire = 1'b0;
      add_free = '0; mul_free = '0; bch_free = '0; lsq_free = '0;
      #3;
      chk("rst_inst", inst, 16'h0000);
      chk("rst_issued", issued, 0);
      chk("rst_stall", stall, 0);
      chk("rst_count", rob_count, 0);

      // basic fetch then issue
      do_reset();
      fetch(4'd0);
      tick();
      chk("s1_inst", inst, 16'h0123);
      chk("s1_func", func, 0);
      chk("s1_rs1", rs1, 1);
      chk("s1_rs2", rs2, 2);
      chk("s1_rd", rd, 3);
      chk("s1_no_issue_yet", issued, 0);
      valid_in = 1'b0;
      tick();
      chk("s1_issued", issued, 1);
      chk("s1_unit", issue_unit, 0);
      chk("s1_slot", issue_slot, 0);
      chk("s1_tag", rob_tag, 0);
      chk("s1_count", rob_count, 1);
      tick();
      chk("s1_pulse_end", issued, 0);
      chk("s1_tag_hold", rob_tag, 0);
      chk("s1_count_hold", rob_count, 1);

      // back-to-back add, mul, div
      do_reset();
      fetch(4'd0); tick();
      fetch(4'd2); tick();
      fetch(4'd3); tick();
      chk("s2_mul_unit", issue_unit, 1);
      chk("s2_mul_slot", issue_slot, 0);
      chk("s2_mul_tag", rob_tag, 1);
      chk("s2_mul_s1b", src1_busy, 0);
      valid_in = 1'b0;
      tick();
      chk("s2_div_issued", issued, 1);
      chk("s2_div_unit", issue_unit, 1);
      chk("s2_div_slot", issue_slot, 1);
      chk("s2_div_tag", rob_tag, 2);
      chk("s2_div_s1b", src1_busy, 0);
      chk("s2_div_s2b", src2_busy, 0);
      chk("s2_count", rob_count, 3);

      // add stations exhausted, release, then reset while stalled
      do_reset();
      fetch(4'd0);
      tick(); tick(); tick(); tick();
      chk("s3_slot2", issue_slot, 2);
      chk("s3_stall", stall, 1);
      pc = 4'd5;
      tick();
      chk("s3_stalled_no_issue", issued, 0);
      chk("s3_inst_held", inst, 16'h0123);
      add_free = 3'b001;
      chk("s3_stall_pre_free", stall, 1);
      tick();
      chk("s3_freed_not_reused", issued, 0);
      chk("s3_unstalled", stall, 0);
      add_free = 3'b000;
      pc = 4'd0;
      tick();
      chk("s3_reissue", issued, 1);
      chk("s3_reissue_slot", issue_slot, 0);
      chk("s3_reissue_tag", rob_tag, 3);
      chk("s3_count", rob_count, 4);
      chk("s3_stall_again", stall, 1);
      valid_in = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("s6_inst", inst, 0);
      chk("s6_issued", issued, 0);
      chk("s6_stall", stall, 0);
      chk("s6_count", rob_count, 0);
      chk("s6_tag", rob_tag, 0);
      chk("s6_slot", issue_slot, 0);
      @(negedge clk1);
      rst_n = 1'b1;
      fetch(4'd2);
      tick();
      chk("s6_refetch", inst, 16'h2789);
      valid_in = 1'b0;
      tick();
      chk("s6_issue_unit", issue_unit, 1);
      chk("s6_issue_slot", issue_slot, 0);
      chk("s6_issue_tag", rob_tag, 0);
      chk("s6_issue_count", rob_count, 1);

      // fill ROB, retire while full, wrap tag
      do_reset();
      for (int i = 0; i < 9; i++) begin
         fetch(fill_seq[i]);
         tick();
      end
      chk("s4_last_issued", issued, 1);
      chk("s4_last_unit", issue_unit, 0);
      chk("s4_last_slot", issue_slot, 1);
      chk("s4_last_tag", rob_tag, 7);
      chk("s4_full", rob_count, 8);
      chk("s4_stall", stall, 1);
      valid_in = 1'b0;
      rob_retire = 1'b1;
      tick();
      chk("s4_retire_still_stall", issued, 0);
      chk("s4_count_after_retire", rob_count, 7);
      rob_retire = 1'b0;
      tick();
      chk("s4_wrap_issued", issued, 1);
      chk("s4_wrap_unit", issue_unit, 1);
      chk("s4_wrap_slot", issue_slot, 0);
      chk("s4_wrap_tag", rob_tag, 0);
      chk("s4_wrap_count", rob_count, 8);

      // NOP, load/store, register status tracking and retire clearing
      do_reset();
      fetch(4'd0); tick();
      fetch(4'd8); tick();
      chk("s5_add_tag", rob_tag, 0);
      chk("s5_nop_inst", inst, 16'hF000);
      chk("s5_nop_stall", stall, 0);
      fetch(4'd4); tick();
      chk("s5_nop_no_issue", issued, 0);
      chk("s5_nop_count", rob_count, 1);
      fetch(4'd4); tick();
      chk("s5_ld_unit", issue_unit, 2);
      chk("s5_ld_slot", issue_slot, 0);
      chk("s5_ld_tag", rob_tag, 1);
      chk("s5_ld_s1b", src1_busy, 0);
      chk("s5_ld_s2b", src2_busy, 0);
      fetch(4'd1); tick();
      chk("s5_ld2_slot", issue_slot, 1);
      chk("s5_ld2_tag", rob_tag, 2);
      valid_in = 1'b0; tick();
      chk("s5_sub_slot", issue_slot, 1);
      chk("s5_sub_tag", rob_tag, 3);
      chk("s5_sub_s1b", src1_busy, 0);
      chk("s5_sub_s2b", src2_busy, 1);
      chk("s5_sub_s2t", src2_tag, 2);
      chk("s5_count4", rob_count, 4);
      rob_retire = 1'b1;
      tick();
      chk("s5_ret1_count", rob_count, 3);
      tick();
      chk("s5_ret2_count", rob_count, 2);
      rob_retire = 1'b0;
      fetch(4'd1); tick();
      valid_in = 1'b0; rob_retire = 1'b1; add_free = 3'b011;
      tick();
      chk("s5_simul_issued", issued, 1);
      chk("s5_simul_slot", issue_slot, 2);
      chk("s5_simul_tag", rob_tag, 4);
      chk("s5_simul_s2b", src2_busy, 1);
      chk("s5_simul_s2t", src2_tag, 2);
      chk("s5_simul_count", rob_count, 2);
      rob_retire = 1'b0; add_free = 3'b000;
      fetch(4'd1); tick();
      valid_in = 1'b0; tick();
      chk("s5_final_slot", issue_slot, 0);
      chk("s5_final_tag", rob_tag, 5);
      chk("s5_final_s2b_cleared", src2_busy, 0);
      chk("s5_final_count", rob_count, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
